// File: rtl/iic_bit_driver.sv
// IIC transmit-side bit engine: drives one bus symbol (START, STOP, WRITE, READ)
// per command as open-drain SCL/SDA enables, with clock stretching and arbitration detection.
module iic_bit_driver #(
    parameter int QUARTER_PERIOD = 4
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Cmd_Valid,
    input  logic [1:0] Cmd,
    input  logic       Wr_Bit,
    output logic       Cmd_Ready,
    input  logic       SCL_In,
    input  logic       SDA_In,
    output logic       SCL_Oe,
    output logic       SDA_Oe,
    output logic       Rd_Valid,
    output logic       Rd_Bit,
    output logic       Arb_Lost
);

    localparam int CW = (QUARTER_PERIOD > 1) ? $clog2(QUARTER_PERIOD) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(QUARTER_PERIOD - 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    cmd_q, cmd_d;
    logic          wr_bit_q, wr_bit_d;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_oe_q, sda_oe_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_bit_q, rd_bit_d;
    logic          arb_lost_q, arb_lost_d;
    logic          quarter_end;

    // Returns {scl_oe, sda_oe} for a command in a given quarter (1 = pull low).
    function automatic logic [1:0] drive(input logic [1:0] c, input logic b, input logic [1:0] q);
        logic [1:0] r;
        r = 2'b00;
        case (c)
            CMD_START: r = (q == 2'd3) ? 2'b11 : (q == 2'd2) ? 2'b01 : 2'b00;
            CMD_STOP:  r = (q == 2'd0) ? 2'b11 : (q == 2'd1) ? 2'b01 : 2'b00;
            CMD_WRITE: r = {(q == 2'd0) || (q == 2'd3), ~b};
            default:   r = {(q == 2'd0) || (q == 2'd3), 1'b0};
        endcase
        return r;
    endfunction

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            cmd_q      <= CMD_START;
            wr_bit_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bit_q   <= 1'b0;
            arb_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cmd_q      <= cmd_d;
            wr_bit_q   <= wr_bit_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            rd_valid_q <= rd_valid_d;
            rd_bit_q   <= rd_bit_d;
            arb_lost_q <= arb_lost_d;
        end
    end

    // Line levels are held between quarter changes, so the bus stays put while idle.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cmd_d       = cmd_q;
        wr_bit_d    = wr_bit_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        rd_valid_d  = 1'b0;
        rd_bit_d    = rd_bit_q;
        arb_lost_d  = 1'b0;
        quarter_end = (count_q == LAST_COUNT);
        case (state_q)
            IDLE: begin
                if (Cmd_Valid) begin
                    state_d              = Q0;
                    count_d              = '0;
                    cmd_d                = Cmd;
                    wr_bit_d             = Wr_Bit;
                    {scl_oe_d, sda_oe_d} = drive(Cmd, Wr_Bit, 2'd0);
                end
            end
            Q0: begin
                if (quarter_end) begin
                    state_d              = Q1;
                    count_d              = '0;
                    {scl_oe_d, sda_oe_d} = drive(cmd_q, wr_bit_q, 2'd1);
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            Q1: begin
                // A slave holding SCL low freezes the quarter until it lets go.
                if (!SCL_In) begin
                    count_d = count_q;
                end else if (quarter_end) begin
                    state_d              = Q2;
                    count_d              = '0;
                    {scl_oe_d, sda_oe_d} = drive(cmd_q, wr_bit_q, 2'd2);
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            Q2: begin
                if (quarter_end) begin
                    count_d = '0;
                    if (cmd_q == CMD_READ) begin
                        rd_bit_d = SDA_In;
                    end
                    if ((cmd_q == CMD_WRITE) && wr_bit_q && !SDA_In) begin
                        arb_lost_d = 1'b1;
                        scl_oe_d   = 1'b0;
                        sda_oe_d   = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d              = Q3;
                        rd_valid_d           = (cmd_q == CMD_READ);
                        {scl_oe_d, sda_oe_d} = drive(cmd_q, wr_bit_q, 2'd3);
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            Q3: begin
                if (quarter_end) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign Cmd_Ready = (state_q == IDLE);
    assign SCL_Oe    = scl_oe_q;
    assign SDA_Oe    = sda_oe_q;
    assign Rd_Valid  = rd_valid_q;
    assign Rd_Bit    = rd_bit_q;
    assign Arb_Lost  = arb_lost_q;

endmodule

// File: tb/tb_iic_bit_driver.sv
// Directed self-checking bench for iic_bit_driver with QUARTER_PERIOD=4 and
// open-drain line models that can be forced low to emulate stretching or a competing master.
module tb_iic_bit_driver;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       Cmd_Valid;
    logic [1:0] Cmd;
    logic       Wr_Bit;
    logic       Cmd_Ready;
    logic       SCL_In;
    logic       SDA_In;
    logic       SCL_Oe;
    logic       SDA_Oe;
    logic       Rd_Valid;
    logic       Rd_Bit;
    logic       Arb_Lost;
    logic       scl_force;
    logic       sda_force;
    int         checks;
    int         errors;

    iic_bit_driver #(.QUARTER_PERIOD(4)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Cmd_Valid (Cmd_Valid),
        .Cmd       (Cmd),
        .Wr_Bit    (Wr_Bit),
        .Cmd_Ready (Cmd_Ready),
        .SCL_In    (SCL_In),
        .SDA_In    (SDA_In),
        .SCL_Oe    (SCL_Oe),
        .SDA_Oe    (SDA_Oe),
        .Rd_Valid  (Rd_Valid),
        .Rd_Bit    (Rd_Bit),
        .Arb_Lost  (Arb_Lost)
    );

    always #5 CLK = ~CLK;

    assign SCL_In = ~SCL_Oe & ~scl_force;
    assign SDA_In = ~SDA_Oe & ~sda_force;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one command and checks every cycle against hand-written per-quarter
    // line levels (bit 3 = Q0 ... bit 0 = Q3, 1 = pulled low).
    task automatic apply_stimulus(input string tag, input logic [1:0] c, input logic b,
                                  input logic [3:0] e_scl, input logic [3:0] e_sda,
                                  input int stretch, input logic force_sda_q2,
                                  input logic e_arb, input logic e_rd_bit, input logic noisy);
        int  q;
        logic arb_seen;
        arb_seen = 1'b0;
        check_output($sformatf("%s ready before", tag), {31'd0, Cmd_Ready}, 32'd1);
        Cmd_Valid = 1'b1;
        Cmd       = c;
        Wr_Bit    = b;
        tick();
        Cmd_Valid = 1'b0;
        for (int t = 0; t < 16 + stretch; t++) begin
            q = (t < 4) ? 0 : (t < 8 + stretch) ? 1 : (t < 12 + stretch) ? 2 : 3;
            scl_force = (t >= 4) && (t < 4 + stretch);
            sda_force = force_sda_q2 && (q == 2);
            if (noisy) begin
                Cmd_Valid = (t < 15);
                Cmd       = 2'b00;
            end
            if (e_arb && (t == 12 + stretch)) begin
                check_output($sformatf("%s arb pulse", tag),
                             {27'd0, SCL_Oe, SDA_Oe, Cmd_Ready, Rd_Valid, Arb_Lost}, 32'b00101);
                tick();
                check_output($sformatf("%s arb after", tag), {30'd0, Arb_Lost, Cmd_Ready}, 32'b01);
                arb_seen = 1'b1;
                break;
            end
            check_output($sformatf("%s t%0d", tag, t),
                         {27'd0, SCL_Oe, SDA_Oe, Cmd_Ready, Rd_Valid, Arb_Lost},
                         {27'd0, e_scl[3-q], e_sda[3-q], 1'b0,
                          (c == 2'b11) && (t == 12 + stretch), 1'b0});
            if ((c == 2'b11) && (t == 12 + stretch)) begin
                check_output($sformatf("%s rd_bit", tag), {31'd0, Rd_Bit}, {31'd0, e_rd_bit});
            end
            tick();
        end
        if (!arb_seen) begin
            check_output($sformatf("%s ready after", tag),
                         {29'd0, Cmd_Ready, Rd_Valid, Arb_Lost}, 32'b100);
        end
        Cmd_Valid = 1'b0;
        scl_force = 1'b0;
        sda_force = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RSTn      = 1'b0;
        Cmd_Valid = 1'b0;
        Cmd       = 2'b00;
        Wr_Bit    = 1'b0;
        scl_force = 1'b0;
        sda_force = 1'b0;
        #3;
        check_output("reset state", {26'd0, SCL_Oe, SDA_Oe, Cmd_Ready, Rd_Valid, Rd_Bit, Arb_Lost},
                     32'b001000);
        #10;
        RSTn = 1'b1;
        tick();

        $display("[TB] START then STOP back-to-back");
        apply_stimulus("start", 2'b00, 1'b0, 4'b0001, 4'b0011, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("stop",  2'b01, 1'b0, 4'b1000, 4'b1100, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] WRITE 0 with requests while busy");
        apply_stimulus("write0", 2'b10, 1'b0, 4'b1001, 4'b1111, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] READ sampling");
        apply_stimulus("read0", 2'b11, 1'b0, 4'b1001, 4'b0000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus("read1", 2'b11, 1'b0, 4'b1001, 4'b0000, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus("write0b", 2'b10, 1'b0, 4'b1001, 4'b1111, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("rd_bit hold", {31'd0, Rd_Bit}, 32'd1);

        $display("[TB] clock stretch of 10 cycles");
        apply_stimulus("stretch", 2'b10, 1'b0, 4'b1001, 4'b1111, 10, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] arbitration loss on WRITE 1");
        apply_stimulus("arb", 2'b10, 1'b1, 4'b1001, 4'b0000, 0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset during Q2 of WRITE 0");
        Cmd_Valid = 1'b1;
        Cmd       = 2'b10;
        Wr_Bit    = 1'b0;
        tick();
        Cmd_Valid = 1'b0;
        repeat (9) tick();
        check_output("pre-reset q2", {30'd0, SCL_Oe, SDA_Oe}, 32'b01);
        #2;
        RSTn = 1'b0;
        #1;
        check_output("async release", {29'd0, SCL_Oe, SDA_Oe, Cmd_Ready}, 32'b001);
        check_output("reset rd_bit", {31'd0, Rd_Bit}, 32'd0);
        #2;
        RSTn = 1'b1;
        tick();
        apply_stimulus("start2", 2'b00, 1'b0, 4'b0001, 4'b0011, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iic_bit_driver.md
Name: iic_bit_driver

Overview:
- Transmit-side bit engine for the IIC path; drives SCL/SDA as open-drain enables, one bus symbol per command: START, STOP, WRITE bit, READ bit.
- Guarantees minimum low/high widths and changes SDA only while SCL is low, except for START/STOP.
- Consumes already-filtered SCL/SDA for clock stretching, read sampling and arbitration detection.
- Sits between the byte-level controller and the IO pads.

Parameters:
QUARTER_PERIOD, 4, CLK cycles per quarter of one SCL bit period; legal range >=2; counter width clog2(QUARTER_PERIOD).

Ports:
CLK  input  1  clock
RSTn  input  1  reset, asynchronous, active-low
Cmd_Valid  input  1  command request
Cmd  input  2  00 START, 01 STOP, 10 WRITE, 11 READ
Wr_Bit  input  1  data bit for WRITE; sampled with the command
Cmd_Ready  output  1  engine idle, can accept a command
SCL_In  input  1  filtered SCL line level
SDA_In  input  1  filtered SDA line level
SCL_Oe  output  1  1 = pull SCL low, 0 = release
SDA_Oe  output  1  1 = pull SDA low, 0 = release
Rd_Valid  output  1  one-cycle pulse, Rd_Bit valid
Rd_Bit  output  1  sampled SDA for READ
Arb_Lost  output  1  one-cycle pulse, arbitration lost

Behaviour:
- Reset (async): state IDLE; SCL_Oe=0, SDA_Oe=0, Cmd_Ready=1, Rd_Valid=0, Rd_Bit=0, Arb_Lost=0, counter=0.
- Reset asserted mid-command releases both lines immediately and discards the command.
- Handshake:
  - Accept on a CLK edge with Cmd_Valid && Cmd_Ready.
  - Cmd and Wr_Bit are registered at acceptance.
  - Cmd_Ready drops the next cycle.
  - Cmd_Valid while busy is ignored (not queued).
- States: IDLE -> Q0 -> Q1 -> Q2 -> Q3 -> IDLE.
  - Each Qn lasts QUARTER_PERIOD cycles.
  - Cmd_Ready=1 again in the cycle after the last Q3 cycle.
  - Command length without stretching is 4*QUARTER_PERIOD cycles.
  - Back-to-back: a command accepted in that first IDLE cycle starts Q0 on the next edge.
- Line drive per quarter:
  - START: Q0 SCL=rel, SDA=rel; Q1 SCL=rel, SDA=rel; Q2 SCL=rel, SDA=low; Q3 SCL=low, SDA=low.
  - STOP: Q0 SCL=low, SDA=low; Q1 SCL=rel, SDA=low; Q2 SCL=rel, SDA=rel; Q3 SCL=rel, SDA=rel.
  - WRITE: Q0 SCL=low, SDA=Wr_Bit (low if 0, rel if 1); Q1 SCL=rel; Q2 SCL=rel; Q3 SCL=low. SDA is held through Q3.
  - READ: same as WRITE with SDA released throughout.
- Outputs are registered; they take the quarter's value on the first cycle of that quarter.
- Clock stretching:
  - In Q1 of every command, the counter holds at 0 while SCL_In==0.
  - Counting starts on the first cycle SCL_In==1.
  - Q1 therefore lasts QUARTER_PERIOD plus the stretch cycles.
  - No other quarter stretches.
- READ sampling:
  - SDA_In is sampled on the last cycle of Q2 into Rd_Bit.
  - Rd_Valid pulses one cycle on the first cycle of Q3.
  - Rd_Bit holds its value until the next READ.
- Arbitration:
  - Applies to WRITE with Wr_Bit=1 only.
  - If SDA_In==0 on the last cycle of Q2: Arb_Lost pulses one cycle, both Oe go to 0, state goes to IDLE (Cmd_Ready=1 next cycle), and Q3 is skipped.
  - No check for START, STOP or READ.
- Counter never wraps: it compares against QUARTER_PERIOD-1, then resets to 0 at the quarter change.

Test Plan (QUARTER_PERIOD=4, SCL_In/SDA_In follow the Oe outputs unless stated):
- START then STOP with no stretch -> SDA falls 8 cycles after START acceptance while SCL is released; SCL low from cycle 12. For the STOP, SCL released 4 cycles after acceptance, SDA released 8 cycles after. Cmd_Ready high 16 cycles after each acceptance.
- WRITE Wr_Bit=0 -> SDA_Oe=1 for all 16 cycles; SCL_Oe=1 during Q0 and Q3, 0 during Q1 and Q2; no Arb_Lost.
- READ with SDA_In forced 1 during Q2 -> Rd_Valid pulses once, at cycle 12 after acceptance, with Rd_Bit=1. Repeat with SDA_In=0 -> Rd_Bit=0.
- Clock stretch: hold SCL_In=0 for 10 cycles after Q1 begins -> the command takes 26 cycles. Line drive otherwise unchanged.
- WRITE Wr_Bit=1 with SDA_In forced 0 in Q2 -> Arb_Lost pulses once, both Oe=0 next cycle, Cmd_Ready=1, no Rd_Valid.
- Assert RSTn low during Q2 of a WRITE 0 -> SCL_Oe and SDA_Oe are 0 immediately, without a clock edge. After release: Cmd_Ready=1, and a new START runs normally.
